pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Parametrised hazard and forwarding controller for the five-stage RISC-V pipeline (IF, ID, EX, MEM, WB).
- Keeps its own shadow copy of the EX, MEM and WB destination-register state.
- Detects RAW and load-use hazards against the instruction in ID and drives the stall and flush controls of the pipeline registers.
- Emits registered forwarding selects aligned with the ID/EX register.
- Handles EX-stage branch redirects and counts stall and flush events.

Parameters:
- REG_ADDR_W, 5, register index width.
- FWD_EN, 1: 1 = forward from MEM/WB and stall only on load-use; 0 = no forwarding, stall until the producer leaves MEM.
- CNT_W, 16, width of the saturating event counters.

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-high
- id_valid  in  1  ID holds a real instruction
- id_rs1  in  REG_ADDR_W  ID source 1
- id_rs2  in  REG_ADDR_W  ID source 2
- id_uses_rs1  in  1  instruction reads rs1
- id_uses_rs2  in  1  instruction reads rs2
- id_rd  in  REG_ADDR_W  ID destination
- id_reg_write  in  1  instruction writes rd
- id_mem_read  in  1  instruction is a load
- ex_branch_taken  in  1  EX resolves a taken branch/jump
- stall_if  out  1  hold PC and IF/ID register
- stall_id  out  1  hold ID; insert bubble into ID/EX
- flush_if  out  1  kill IF/ID contents
- flush_id  out  1  kill ID/EX contents
- fwd_a_sel  out  2  EX operand1 source: 00 regfile, 01 EX/MEM result, 10 MEM/WB result
- fwd_b_sel  out  2  EX operand2 source, same encoding
- stall_count  out  CNT_W  cycles with stall_id=1
- flush_count  out  CNT_W  cycles with flush_id=1

Behaviour:
- Shadow stages ex_s, mem_s, wb_s each hold {valid, rd, reg_write, mem_read}.
- Reset (async): all valid bits 0, all outputs 0, counters 0. Reset asserted mid-stall or mid-flush clears everything immediately; the first post-reset cycle sees an empty pipe.
- dep(src, S) = id_valid & uses_src & (src != 0) & S.valid & S.reg_write & (S.rd == src). x0 never creates a hazard.
- The register file is write-through, so a WB-stage producer never causes a stall.
- Hazard rule, FWD_EN=1: hazard = (dep(rs1,ex_s) | dep(rs2,ex_s)) & ex_s.mem_read, i.e. load-use only.
- Hazard rule, FWD_EN=0: hazard = any dep against ex_s or mem_s.
- redirect = ex_branch_taken & ex_s.valid. ex_branch_taken is ignored when ex_s is invalid.
- Combinational outputs: stall_if = stall_id = hazard & ~redirect; flush_if = flush_id = redirect. Redirect has priority over stall.
- Clock edge, shadow advance: wb_s <= mem_s; mem_s <= ex_s.
- Clock edge, ex_s update: if redirect or stall_id, ex_s.valid <= 0 (bubble); otherwise ex_s <= ID fields with valid = id_valid.
- Forward selects (FWD_EN=1), computed in ID and registered on advance:
  - sel = 01 if dep(src, ex_s), since that producer will be in MEM when the consumer is in EX.
  - else sel = 10 if dep(src, mem_s).
  - else sel = 00.
  - The newer producer wins.
- Forward selects when bubbling (stall or redirect) or when FWD_EN=0: register 00.
- Load-use case: after the one-cycle stall the load is in mem_s, so the consumer gets sel 10.
- stall_count increments when stall_id=1; flush_count increments when flush_id=1. Both saturate at all-ones and never wrap.
- Latency: stall and flush outputs are same-cycle combinational; fwd selects appear one cycle after ID, i.e. with the instruction in EX.

Test Plan:
- Reset mid-stall: load x5 in EX, consumer in ID, reset pulsed → all outputs 0 within the reset cycle; counters 0.
- Back-to-back ALU, FWD_EN=1: `add x3,x1,x2` then `sub x4,x3,x1` → no stall; next cycle fwd_a_sel=01, fwd_b_sel=00.
- Distance-2 dependency: producer x7, independent instruction, then consumer of x7 in rs2 → fwd_b_sel=10.
- Load-use: `lw x5` then `add x6,x5,x5` → stall_if=stall_id=1 for exactly 1 cycle, stall_count=1; then fwd_a_sel=fwd_b_sel=10.
- FWD_EN=0: same `add`/`sub` pair → stall for 2 cycles; fwd selects stay 00.
- Branch vs stall: ex_branch_taken=1 with valid EX while a load-use hazard exists → flush_if=flush_id=1, stall_id=0, flush_count+1, ex_s bubble.
- Edge cases: dependency on x0 → no stall and sel 00. Counters forced near max (CNT_W=2) saturate at 3.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Hazard detection and forwarding control for a five-stage in-order pipeline.
// Tracks EX/MEM/WB destination state in shadow stages and drives stall, flush and forward selects.
module pipe_hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter bit FWD_EN     = 1'b1,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  ex_branch_taken,
    output logic                  stall_if,
    output logic                  stall_id,
    output logic                  flush_if,
    output logic                  flush_id,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic [CNT_W-1:0]      stall_count,
    output logic [CNT_W-1:0]      flush_count
);

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  mem_read;
    } stage_t;

    stage_t ex_s, mem_s, wb_s;

    logic dep_ex_a, dep_ex_b, dep_mem_a, dep_mem_b;
    logic hazard, redirect, bubble;
    logic [1:0] fwd_a_next, fwd_b_next;

    function automatic logic dep(input logic valid, input logic uses,
                                 input logic [REG_ADDR_W-1:0] src, input stage_t s);
        return valid & uses & (src != '0) & s.valid & s.reg_write & (s.rd == src);
    endfunction

    always_comb begin
        dep_ex_a  = dep(id_valid, id_uses_rs1, id_rs1, ex_s);
        dep_ex_b  = dep(id_valid, id_uses_rs2, id_rs2, ex_s);
        dep_mem_a = dep(id_valid, id_uses_rs1, id_rs1, mem_s);
        dep_mem_b = dep(id_valid, id_uses_rs2, id_rs2, mem_s);
    end

    // Write-through regfile: a WB producer never needs a stall.
    always_comb begin
        hazard = 1'b0;
        if (FWD_EN)
            hazard = (dep_ex_a | dep_ex_b) & ex_s.mem_read;
        else
            hazard = dep_ex_a | dep_ex_b | dep_mem_a | dep_mem_b;
    end

    assign redirect = ex_branch_taken & ex_s.valid;
    assign stall_id = hazard & ~redirect;
    assign stall_if = stall_id;
    assign flush_id = redirect;
    assign flush_if = redirect;
    assign bubble   = redirect | stall_id;

    // EX producer will sit in MEM when the consumer reaches EX, so it maps to 01 and wins.
    always_comb begin
        fwd_a_next = 2'b00;
        fwd_b_next = 2'b00;
        if (FWD_EN && !bubble) begin
            if (dep_ex_a)       fwd_a_next = 2'b01;
            else if (dep_mem_a) fwd_a_next = 2'b10;
            if (dep_ex_b)       fwd_b_next = 2'b01;
            else if (dep_mem_b) fwd_b_next = 2'b10;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_s      <= '0;
            mem_s     <= '0;
            wb_s      <= '0;
            fwd_a_sel <= '0;
            fwd_b_sel <= '0;
        end else begin
            wb_s  <= mem_s;
            mem_s <= ex_s;
            if (bubble)
                ex_s.valid <= 1'b0;
            else
                ex_s <= '{valid: id_valid, rd: id_rd, reg_write: id_reg_write, mem_read: id_mem_read};
            fwd_a_sel <= fwd_a_next;
            fwd_b_sel <= fwd_b_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (stall_id && stall_count != '1) stall_count <= stall_count + 1'b1;
            if (flush_id && flush_count != '1) flush_count <= flush_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: forwarding, no-forwarding and narrow-counter
// instances share one stimulus stream; each scenario checks the relevant instance.
module tb_pipe_hazard_ctrl;

    logic       clk;
    logic       reset;
    logic       id_valid;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       id_uses_rs1, id_uses_rs2, id_reg_write, id_mem_read;
    logic       ex_branch_taken;

    logic        f_stall_if, f_stall_id, f_flush_if, f_flush_id;
    logic [1:0]  f_fwd_a, f_fwd_b;
    logic [15:0] f_stall_cnt, f_flush_cnt;

    logic        n_stall_if, n_stall_id, n_flush_if, n_flush_id;
    logic [1:0]  n_fwd_a, n_fwd_b;
    logic [15:0] n_stall_cnt, n_flush_cnt;

    logic        s_stall_if, s_stall_id, s_flush_if, s_flush_id;
    logic [1:0]  s_fwd_a, s_fwd_b;
    logic [1:0]  s_stall_cnt, s_flush_cnt;

    int unsigned n_checks;
    int unsigned n_fail;

    pipe_hazard_ctrl #(.REG_ADDR_W(5), .FWD_EN(1'b1), .CNT_W(16)) u_fwd (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .ex_branch_taken(ex_branch_taken),
        .stall_if(f_stall_if), .stall_id(f_stall_id), .flush_if(f_flush_if), .flush_id(f_flush_id),
        .fwd_a_sel(f_fwd_a), .fwd_b_sel(f_fwd_b), .stall_count(f_stall_cnt), .flush_count(f_flush_cnt)
    );

    pipe_hazard_ctrl #(.REG_ADDR_W(5), .FWD_EN(1'b0), .CNT_W(16)) u_nofwd (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .ex_branch_taken(ex_branch_taken),
        .stall_if(n_stall_if), .stall_id(n_stall_id), .flush_if(n_flush_if), .flush_id(n_flush_id),
        .fwd_a_sel(n_fwd_a), .fwd_b_sel(n_fwd_b), .stall_count(n_stall_cnt), .flush_count(n_flush_cnt)
    );

    pipe_hazard_ctrl #(.REG_ADDR_W(5), .FWD_EN(1'b1), .CNT_W(2)) u_sat (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .ex_branch_taken(ex_branch_taken),
        .stall_if(s_stall_if), .stall_id(s_stall_id), .flush_if(s_flush_if), .flush_id(s_flush_id),
        .fwd_a_sel(s_fwd_a), .fwd_b_sel(s_fwd_b), .stall_count(s_stall_cnt), .flush_count(s_flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", tag, actual, expected);
        end
    endtask

    task automatic issue(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic [4:0] rd,
                         input logic rw, input logic mr);
        id_valid     = v;
        id_rs1       = rs1;
        id_rs2       = rs2;
        id_uses_rs1  = u1;
        id_uses_rs2  = u2;
        id_rd        = rd;
        id_reg_write = rw;
        id_mem_read  = mr;
    endtask

    task automatic nop();
        issue(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    // Advance one edge and leave inputs free to change just after it; sample on negedge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ex_branch_taken = 1'b0;
        nop();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        do_reset();
        sample();
        check_eq("reset_stall_id", 32'(f_stall_id), 32'd0);
        check_eq("reset_flush_id", 32'(f_flush_id), 32'd0);
        check_eq("reset_stall_cnt", 32'(f_stall_cnt), 32'd0);

        // Reset mid-stall: lw x5 in EX, add x6,x5,x5 in ID
        tick(); issue(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1);
        tick(); issue(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
        sample();
        check_eq("rst_pre_stall_fwd", 32'(f_stall_id), 32'd1);
        tick();
        sample();
        check_eq("rst_pre_stall_nofwd", 32'(n_stall_id), 32'd1);
        check_eq("rst_pre_cnt_nofwd", 32'(n_stall_cnt), 32'd1);
        check_eq("rst_pre_cnt_fwd", 32'(f_stall_cnt), 32'd1);
        reset = 1'b1;
        #1;
        check_eq("rst_mid_stall_id", 32'(n_stall_id), 32'd0);
        check_eq("rst_mid_stall_if", 32'(n_stall_if), 32'd0);
        check_eq("rst_mid_cnt_nofwd", 32'(n_stall_cnt), 32'd0);
        check_eq("rst_mid_cnt_fwd", 32'(f_stall_cnt), 32'd0);
        check_eq("rst_mid_fwd_a", 32'(f_fwd_a), 32'd0);
        do_reset();
        issue(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
        sample();
        check_eq("post_rst_empty_pipe", 32'(n_stall_id), 32'd0);

        // Back-to-back ALU: add x3,x1,x2 ; sub x4,x3,x1
        do_reset();
        issue(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
        sample();
        check_eq("alu_prod_stall", 32'(f_stall_id), 32'd0);
        tick(); issue(1'b1, 5'd3, 5'd1, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);
        sample();
        check_eq("alu_cons_stall", 32'(f_stall_id), 32'd0);
        tick(); nop();
        sample();
        check_eq("alu_fwd_a", 32'(f_fwd_a), 32'd1);
        check_eq("alu_fwd_b", 32'(f_fwd_b), 32'd0);

        // Distance 2: add x7 ; add x8 ; add x9,x1,x7
        do_reset();
        issue(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0);
        tick(); issue(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
        tick(); issue(1'b1, 5'd1, 5'd7, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
        sample();
        check_eq("dist2_stall", 32'(f_stall_id), 32'd0);
        tick(); nop();
        sample();
        check_eq("dist2_fwd_a", 32'(f_fwd_a), 32'd0);
        check_eq("dist2_fwd_b", 32'(f_fwd_b), 32'd2);

        // Load-use: lw x5 ; add x6,x5,x5
        do_reset();
        issue(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1);
        tick(); issue(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
        sample();
        check_eq("lu_stall_if", 32'(f_stall_if), 32'd1);
        check_eq("lu_stall_id", 32'(f_stall_id), 32'd1);
        tick();
        sample();
        check_eq("lu_stall_released", 32'(f_stall_id), 32'd0);
        check_eq("lu_stall_cnt", 32'(f_stall_cnt), 32'd1);
        tick(); nop();
        sample();
        check_eq("lu_fwd_a", 32'(f_fwd_a), 32'd2);
        check_eq("lu_fwd_b", 32'(f_fwd_b), 32'd2);
        check_eq("lu_stall_cnt_final", 32'(f_stall_cnt), 32'd1);

        // No forwarding: add x3 ; sub x4,x3,x1 stalls two cycles
        do_reset();
        issue(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
        tick(); issue(1'b1, 5'd3, 5'd1, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);
        sample();
        check_eq("nf_stall_c1", 32'(n_stall_id), 32'd1);
        tick();
        sample();
        check_eq("nf_stall_c2", 32'(n_stall_id), 32'd1);
        tick();
        sample();
        check_eq("nf_stall_c3", 32'(n_stall_id), 32'd0);
        check_eq("nf_stall_cnt", 32'(n_stall_cnt), 32'd2);
        tick(); nop();
        sample();
        check_eq("nf_fwd_a", 32'(n_fwd_a), 32'd0);
        check_eq("nf_fwd_b", 32'(n_fwd_b), 32'd0);

        // Branch redirect while a load-use hazard exists
        do_reset();
        issue(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1);
        tick(); issue(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
        ex_branch_taken = 1'b1;
        sample();
        check_eq("br_flush_if", 32'(f_flush_if), 32'd1);
        check_eq("br_flush_id", 32'(f_flush_id), 32'd1);
        check_eq("br_stall_id", 32'(f_stall_id), 32'd0);
        check_eq("br_stall_if", 32'(f_stall_if), 32'd0);
        tick(); nop();
        sample();
        check_eq("br_flush_cnt", 32'(f_flush_cnt), 32'd1);
        check_eq("br_stall_cnt", 32'(f_stall_cnt), 32'd0);
        check_eq("br_bubble_ignored", 32'(f_flush_id), 32'd0);
        check_eq("br_fwd_a", 32'(f_fwd_a), 32'd0);
        tick(); ex_branch_taken = 1'b0;
        sample();
        check_eq("br_flush_cnt_hold", 32'(f_flush_cnt), 32'd1);

        // x0 dependency: lw x0 ; add x6,x0,x0
        do_reset();
        issue(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1);
        tick(); issue(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
        sample();
        check_eq("x0_stall", 32'(f_stall_id), 32'd0);
        tick(); nop();
        sample();
        check_eq("x0_fwd_a", 32'(f_fwd_a), 32'd0);
        check_eq("x0_fwd_b", 32'(f_fwd_b), 32'd0);

        // Saturation on a 2-bit counter: five load-use stalls, five flushes
        do_reset();
        for (int i = 0; i < 5; i++) begin
            issue(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1);
            tick(); issue(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
            tick();
            tick();
            if (i == 0) begin
                sample();
                check_eq("sat_stall_cnt_first", 32'(s_stall_cnt), 32'd1);
                tick();
            end
        end
        sample();
        check_eq("sat_stall_cnt", 32'(s_stall_cnt), 32'd3);
        tick();
        for (int i = 0; i < 5; i++) begin
            issue(1'b1, 5'd2, 5'd3, 1'b1, 1'b1, 5'd1, 1'b1, 1'b0);
            ex_branch_taken = 1'b0;
            tick(); nop();
            ex_branch_taken = 1'b1;
            tick();
        end
        ex_branch_taken = 1'b0;
        sample();
        check_eq("sat_flush_cnt", 32'(s_flush_cnt), 32'd3);
        check_eq("sat_stall_cnt_hold", 32'(s_stall_cnt), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
